// File: rtl/alu_issue_stage.sv
// Two-entry issue pipeline for a MIPS integer ALU: S1 holds the decoded op and
// operands that drive the external ALU, S2 captures its result for write-back.
module alu_issue_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic [4:0]  rd_o,
    output logic        wb_en_o,
    output logic        branch_o,
    output logic        taken_o,
    output logic        illegal_o
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Decoded fields of the incoming instruction
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] dec_src1;
    logic [31:0] dec_src2;
    logic [3:0]  dec_ctrl;
    logic [4:0]  dec_rd;
    logic        dec_wb_en;
    logic        dec_branch;
    logic        dec_bne;
    logic        dec_illegal;

    // S1 state
    logic        s1_valid_reg;
    logic [31:0] s1_src1_reg;
    logic [31:0] s1_src2_reg;
    logic [3:0]  s1_ctrl_reg;
    logic [4:0]  s1_rd_reg;
    logic        s1_wb_en_reg;
    logic        s1_branch_reg;
    logic        s1_bne_reg;
    logic        s1_illegal_reg;

    // S2 state
    logic        s2_valid_reg;
    logic [31:0] s2_result_reg;
    logic        s2_zero_reg;
    logic [4:0]  s2_rd_reg;
    logic        s2_wb_en_reg;
    logic        s2_branch_reg;
    logic        s2_taken_reg;
    logic        s2_illegal_reg;

    logic advance;
    logic accept;
    logic drain;

    assign opcode = instr_i[31:26];
    assign funct  = instr_i[5:0];

    always_comb begin
        dec_src1    = rs_data_i;
        dec_src2    = rt_data_i;
        dec_ctrl    = ALU_ADD;
        dec_rd      = 5'd0;
        dec_wb_en   = 1'b0;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            6'h00: begin
                dec_rd    = instr_i[15:11];
                dec_wb_en = 1'b1;
                case (funct)
                    6'h20:   dec_ctrl = ALU_ADD;
                    6'h22:   dec_ctrl = ALU_SUB;
                    6'h24:   dec_ctrl = ALU_AND;
                    6'h25:   dec_ctrl = ALU_OR;
                    6'h27:   dec_ctrl = ALU_NOR;
                    6'h2A:   dec_ctrl = ALU_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h08: begin
                dec_ctrl  = ALU_ADD;
                dec_src2  = {{16{instr_i[15]}}, instr_i[15:0]};
                dec_rd    = instr_i[20:16];
                dec_wb_en = 1'b1;
            end
            6'h0A: begin
                dec_ctrl  = ALU_SLT;
                dec_src2  = {{16{instr_i[15]}}, instr_i[15:0]};
                dec_rd    = instr_i[20:16];
                dec_wb_en = 1'b1;
            end
            6'h0D: begin
                dec_ctrl  = ALU_OR;
                dec_src2  = {16'h0000, instr_i[15:0]};
                dec_rd    = instr_i[20:16];
                dec_wb_en = 1'b1;
            end
            6'h04, 6'h05: begin
                dec_ctrl   = ALU_SUB;
                dec_branch = 1'b1;
                dec_bne    = opcode[0];
            end
            default: dec_illegal = 1'b1;
        endcase
        // Undecodable words issue as a harmless 0 + 0 with no side effects
        if (dec_illegal) begin
            dec_ctrl   = ALU_ADD;
            dec_src1   = 32'd0;
            dec_src2   = 32'd0;
            dec_rd     = 5'd0;
            dec_wb_en  = 1'b0;
            dec_branch = 1'b0;
            dec_bne    = 1'b0;
        end
    end

    assign advance    = s1_valid_reg && (!s2_valid_reg || out_ready_i);
    assign in_ready_o = !s1_valid_reg || advance;
    assign accept     = in_valid_i && in_ready_o;
    assign drain      = s2_valid_reg && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg   <= 1'b0;
            s1_src1_reg    <= 32'd0;
            s1_src2_reg    <= 32'd0;
            s1_ctrl_reg    <= 4'd0;
            s1_rd_reg      <= 5'd0;
            s1_wb_en_reg   <= 1'b0;
            s1_branch_reg  <= 1'b0;
            s1_bne_reg     <= 1'b0;
            s1_illegal_reg <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_reg   <= 1'b1;
                s1_src1_reg    <= dec_src1;
                s1_src2_reg    <= dec_src2;
                s1_ctrl_reg    <= dec_ctrl;
                s1_rd_reg      <= dec_rd;
                s1_wb_en_reg   <= dec_wb_en;
                s1_branch_reg  <= dec_branch;
                s1_bne_reg     <= dec_bne;
                s1_illegal_reg <= dec_illegal;
            end else if (advance) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= 32'd0;
            s2_zero_reg    <= 1'b0;
            s2_rd_reg      <= 5'd0;
            s2_wb_en_reg   <= 1'b0;
            s2_branch_reg  <= 1'b0;
            s2_taken_reg   <= 1'b0;
            s2_illegal_reg <= 1'b0;
        end else begin
            if (advance) begin
                s2_valid_reg   <= 1'b1;
                s2_result_reg  <= alu_result_i;
                s2_zero_reg    <= alu_zero_i;
                s2_rd_reg      <= s1_rd_reg;
                s2_wb_en_reg   <= s1_wb_en_reg;
                s2_branch_reg  <= s1_branch_reg;
                s2_taken_reg   <= s1_branch_reg && (alu_zero_i ^ s1_bne_reg);
                s2_illegal_reg <= s1_illegal_reg;
            end else if (drain) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    assign alu_src1_o  = s1_src1_reg;
    assign alu_src2_o  = s1_src2_reg;
    assign alu_ctrl_o  = s1_ctrl_reg;
    assign out_valid_o = s2_valid_reg;
    assign result_o    = s2_result_reg;
    assign zero_o      = s2_zero_reg;
    assign rd_o        = s2_rd_reg;
    assign wb_en_o     = s2_wb_en_reg;
    assign branch_o    = s2_branch_reg;
    assign taken_o     = s2_taken_reg;
    assign illegal_o   = s2_illegal_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU attached to
// the operand/result ports; expected values are hand-computed constants.
module tb_alu_issue_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic [4:0]  rd_o;
    logic        wb_en_o;
    logic        branch_o;
    logic        taken_o;
    logic        illegal_o;

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    logic [31:0] rx_q[$];
    logic        saw_stall;

    always #5 clk_i = ~clk_i;

    alu_issue_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .result_o     (result_o),
        .zero_o       (zero_o),
        .rd_o         (rd_o),
        .wb_en_o      (wb_en_o),
        .branch_o     (branch_o),
        .taken_o      (taken_o),
        .illegal_o    (illegal_o)
    );

    always_comb begin
        alu_result_i = 32'd0;
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
            4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
            4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
            4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
            4'b0111: alu_result_i = {31'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
            4'b1100: alu_result_i = ~(alu_src1_o | alu_src2_o);
            default: alu_result_i = 32'd0;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    always @(posedge clk_i) begin
        if (mon_en && !rst_i && out_valid_o && out_ready_i)
            rx_q.push_back(result_o);
    end

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Called 1 time unit after a rising edge; leaves S1 loaded with the word.
    task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        instr_i    = instr;
        rs_data_i  = rs;
        rt_data_i  = rt;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        $display("issue instr=0x%08h rs=0x%08h rt=0x%08h", instr, rs, rt);
    endtask

    // One instruction in isolation: check S1 operands, then S2 outputs.
    task automatic run_one(input string name, input logic [31:0] instr,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input logic [31:0] exp_src2, input logic [31:0] exp_res,
                           input logic [4:0] exp_rd, input logic [5:0] exp_flags);
        issue(instr, rs, rt);
        check_eq({name, "_src2"}, alu_src2_o, exp_src2);
        @(posedge clk_i);
        #1;
        check_eq({name, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        check_eq({name, "_result"}, result_o, exp_res);
        check_eq({name, "_rd"}, {27'd0, rd_o}, {27'd0, exp_rd});
        // flags: zero, wb_en, branch, taken, illegal, (spare)
        check_eq({name, "_flags"},
                 {26'd0, zero_o, wb_en_o, branch_o, taken_o, illegal_o, 1'b0},
                 {26'd0, exp_flags});
    endtask

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        instr_i     = 32'd0;
        rs_data_i   = 32'd0;
        rt_data_i   = 32'd0;
        out_ready_i = 1'b1;
        saw_stall   = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        check_eq("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check_eq("rst_result", result_o, 32'd0);
        check_eq("rst_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
        check_eq("rst_flags", {24'd0, rd_o, zero_o, wb_en_o, branch_o}, 32'd0);

        //        name     instr         rs            rt         src2          result        rd    z w b t i -
        run_one("add",   32'h00221820, 32'd5,        32'd7,     32'd7,        32'd12,       5'd3, 6'b010000);
        run_one("addi",  32'h2022FFFF, 32'd1,        32'd0,     32'hFFFFFFFF, 32'd0,        5'd2, 6'b110000);
        run_one("ori",   32'h34228000, 32'd1,        32'd0,     32'h00008000, 32'h00008001, 5'd2, 6'b010000);
        run_one("sub",   32'h00222822, 32'd10,       32'd3,     32'd3,        32'd7,        5'd5, 6'b010000);
        run_one("nor",   32'h00223027, 32'd0,        32'd0,     32'd0,        32'hFFFFFFFF, 5'd6, 6'b010000);
        run_one("slt",   32'h0022202A, 32'hFFFFFFFF, 32'd1,     32'd1,        32'd1,        5'd4, 6'b010000);
        run_one("beq",   32'h10220003, 32'd9,        32'd9,     32'd9,        32'd0,        5'd0, 6'b101100);
        run_one("bne",   32'h14220003, 32'd9,        32'd9,     32'd9,        32'd0,        5'd0, 6'b101000);
        run_one("bne_t", 32'h14220003, 32'd9,        32'd4,     32'd4,        32'd5,        5'd0, 6'b001100);
        run_one("ill_op",32'hFC000000, 32'd5,        32'd7,     32'd0,        32'd0,        5'd0, 6'b100010);
        run_one("ill_fn",32'h00221801, 32'd5,        32'd7,     32'd0,        32'd0,        5'd0, 6'b100010);

        // Back-to-back stream with a three-cycle output stall
        @(posedge clk_i);
        #1;
        rx_q.delete();
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    int waitc;
                    waitc      = 0;
                    instr_i    = 32'h00221820;
                    rs_data_i  = 32'd10 * i + 32'd1;
                    rt_data_i  = i;
                    in_valid_i = 1'b1;
                    #3;
                    while (!in_ready_o && waitc < 20) begin
                        saw_stall = 1'b1;
                        @(posedge clk_i);
                        #4;
                        waitc++;
                    end
                    check_eq("stream_accept_in_time", {31'd0, waitc < 20}, 32'd1);
                    @(posedge clk_i);
                    #1;
                    $display("stream accept %0d rs=%0d rt=%0d", i, 10 * i + 1, i);
                end
                in_valid_i = 1'b0;
            end
            begin
                repeat (2) @(posedge clk_i);
                #1;
                out_ready_i = 1'b0;
                @(posedge clk_i);
                #2;
                check_eq("stall_hold_valid", {31'd0, out_valid_o}, 32'd1);
                check_eq("stall_hold_result", result_o, 32'd1);
                repeat (2) @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        for (int c = 0; c < 20 && rx_q.size() < 4; c++) @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        check_eq("stream_in_ready_dropped", {31'd0, saw_stall}, 32'd1);
        check_eq("stream_count", rx_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] got;
            got = (i < rx_q.size()) ? rx_q[i] : 32'hDEADBEEF;
            $display("stream result %0d = %0d", i, got);
            check_eq("stream_order", got, 32'd11 * i + 32'd1);
        end

        // Fill both stages, then reset with a new input pending
        out_ready_i = 1'b0;
        issue(32'h00221820, 32'd5, 32'd7);
        issue(32'h00222822, 32'd10, 32'd3);
        check_eq("full_in_ready", {31'd0, in_ready_o}, 32'd0);
        check_eq("full_out_valid", {31'd0, out_valid_o}, 32'd1);
        instr_i    = 32'h00221820;
        in_valid_i = 1'b1;
        rst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        check_eq("mid_rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check_eq("mid_rst_result", result_o, 32'd0);
        check_eq("mid_rst_src", alu_src1_o | alu_src2_o, 32'd0);
        check_eq("mid_rst_outs",
                 {20'd0, alu_ctrl_o, rd_o, zero_o, wb_en_o, branch_o, taken_o, illegal_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("mid_rst_no_ghost", {31'd0, out_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
